// File: rtl/dt_result_scan.sv
// Raster scan of the distance-transform result RAM, reducing the map to
// peak value, first peak location, peak count and nonzero area.
module dt_result_scan #(
    parameter int unsigned IMG_LOG2 = 7,
    parameter int unsigned DW       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    res_rd,
    output logic [2*IMG_LOG2-1:0]   res_addr,
    input  logic [DW-1:0]           res_di,
    output logic                    busy,
    output logic                    done,
    output logic [DW-1:0]           max_val,
    output logic [2*IMG_LOG2-1:0]   max_addr,
    output logic [2*IMG_LOG2:0]     max_cnt,
    output logic [2*IMG_LOG2:0]     area
);

    localparam int unsigned AW        = 2 * IMG_LOG2;
    localparam int unsigned CW        = AW + 1;
    localparam int unsigned LAST_ADDR = (1 << AW) - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    // Outstanding-read tag: the address whose data arrives next cycle.
    logic            r_pend;
    logic [AW-1:0]   r_pend_addr;

    logic            w_rd_nxt;
    logic [AW-1:0]   w_addr_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic [DW-1:0]   w_max_val_nxt;
    logic [AW-1:0]   w_max_addr_nxt;
    logic [CW-1:0]   w_max_cnt_nxt;
    logic [CW-1:0]   w_area_nxt;
    logic            w_pend_nxt;
    logic [AW-1:0]   w_pend_addr_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            res_rd      <= 1'b0;
            res_addr    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            max_val     <= '0;
            max_addr    <= '0;
            max_cnt     <= '0;
            area        <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_addr <= w_pend_addr_nxt;
            res_rd      <= w_rd_nxt;
            res_addr    <= w_addr_nxt;
            busy        <= w_busy_nxt;
            done        <= w_done_nxt;
            max_val     <= w_max_val_nxt;
            max_addr    <= w_max_addr_nxt;
            max_cnt     <= w_max_cnt_nxt;
            area        <= w_area_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rd_nxt        = res_rd;
        w_addr_nxt      = res_addr;
        w_busy_nxt      = busy;
        w_done_nxt      = done;
        w_max_val_nxt   = max_val;
        w_max_addr_nxt  = max_addr;
        w_max_cnt_nxt   = max_cnt;
        w_area_nxt      = area;
        w_pend_nxt      = res_rd;
        w_pend_addr_nxt = res_addr;

        // Accumulate the pixel returned for the request issued last cycle.
        if (r_pend) begin
            if (r_pend_addr == '0) begin
                w_max_val_nxt  = res_di;
                w_max_addr_nxt = '0;
                w_max_cnt_nxt  = CW'(1);
                w_area_nxt     = CW'(res_di != '0);
            end else begin
                if (res_di > max_val) begin
                    w_max_val_nxt  = res_di;
                    w_max_addr_nxt = r_pend_addr;
                    w_max_cnt_nxt  = CW'(1);
                end else if (res_di == max_val) begin
                    w_max_cnt_nxt  = max_cnt + CW'(1);
                end
                if (res_di != '0) begin
                    w_area_nxt = area + CW'(1);
                end
            end
        end

        case (r_state)
            ST_IDLE, ST_FINISH: begin
                if (start) begin
                    w_state_nxt    = ST_SCAN;
                    w_rd_nxt       = 1'b1;
                    w_addr_nxt     = '0;
                    w_busy_nxt     = 1'b1;
                    w_done_nxt     = 1'b0;
                    w_max_val_nxt  = '0;
                    w_max_addr_nxt = '0;
                    w_max_cnt_nxt  = '0;
                    w_area_nxt     = '0;
                end
            end
            ST_SCAN: begin
                if (res_addr == AW'(LAST_ADDR)) begin
                    w_state_nxt = ST_DRAIN;
                    w_rd_nxt    = 1'b0;
                end else begin
                    w_addr_nxt  = res_addr + AW'(1);
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_FINISH;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/dt_result_scan.md
Name: dt_result_scan

Overview:
- Post-processing stage directly downstream of the distance-transform block.
- Starts when the DT block's done pulses.
- Streams the 128x128 8-bit distance map back out of the res RAM, one pixel per clock, in raster order.
- Reduces the map to summary statistics: peak distance, first peak location, count of pixels at the peak, and foreground area (nonzero pixels). These are held stable for the downstream controller.

Parameters:
- IMG_LOG2, 7, log2 of image side; image is 2^IMG_LOG2 square; address width = 2*IMG_LOG2.
- DW, 8, distance value width.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse, connected to DT done rising edge
- res_rd  output  1  read strobe to res RAM
- res_addr  output  14  read address, row-major {y,x}
- res_di  input  8  read data from res RAM
- busy  output  1  high from start acceptance until done
- done  output  1  high when results valid; held until next accepted start
- max_val  output  8  largest distance value in map
- max_addr  output  14  raster address of first pixel equal to max_val
- max_cnt  output  15  number of pixels equal to max_val (1..16384)
- area  output  15  number of nonzero pixels (0..16384)

Behaviour:
- Reset (async, reset=0): state IDLE. res_rd=0, res_addr=0, busy=0, done=0, max_val=0, max_addr=0, max_cnt=0, area=0. All outputs are registered.
- Reset mid-scan aborts immediately. No partial results remain; a new start is required.
- RAM timing: a request presented in cycle c returns data valid in cycle c+1. The block samples it at the end of cycle c+1. One outstanding-read pipeline register carries the address alongside the request.
- States:
  - IDLE: start=1 -> SCAN. At the same edge: res_rd<=1, res_addr<=0, busy<=1, done<=0. Accumulators clear to max_val=0, max_addr=0, max_cnt=0, area=0.
  - SCAN: res_rd=1 every cycle; res_addr increments by 1 per cycle, 0..16383. At the edge after 16383 is presented: res_rd<=0, res_addr unchanged, -> DRAIN.
  - DRAIN: one cycle; the last pixel (16383) is sampled. At that edge: busy<=0, done<=1, -> FINISH.
  - FINISH: outputs frozen, done=1. start=1 -> same actions as IDLE start (restart).
- Per sampled pixel v at address a (first sample is the pixel at address 0):
  - v>max_val: max_val<=v, max_addr<=a, max_cnt<=1.
  - v==max_val: max_cnt<=max_cnt+1. max_addr unchanged, so the first occurrence wins.
  - v!=0: area<=area+1.
  - The pixel at address 0 always initialises the accumulators: max_val<=v, max_addr<=0, max_cnt<=1, area<=(v!=0).
- Latency: start sampled at edge E -> done=1 after edge E+16385. Total read cycles = 16384 exactly, with res_rd high for 16384 consecutive cycles.
- start while busy (SCAN/DRAIN) is ignored.
- Counters cannot overflow: 15 bits hold 16384.
- res_addr wrap: never presents an address beyond 16383; never wraps to 0 during a scan.
- During a scan, intermediate values on max_*/area are don't-care to consumers. They are valid only while done=1.

Test Plan:
- All-zero map, start pulse -> done after exactly 16385 edges. max_val=0, max_addr=0, max_cnt=16384, area=0. res_rd high for exactly 16384 cycles.
- Single 5 at (y=40,x=17), rest zero -> max_val=5, max_addr=0x1411 (40*128+17=5137), max_cnt=1, area=1.
- Value 9 at addresses 300, 12000, 16383; value 3 at addresses 0..99; rest zero -> max_val=9, max_addr=300, max_cnt=3, area=103.
- Ramp map v=addr[7:0] -> max_val=255, max_addr=255, max_cnt=64, area=16320.
- start re-pulsed at cycle 500 of a scan -> ignored; done still after 16385 edges from the first start. A second start in FINISH gives a fresh scan with identical results; done drops the edge after start.
- reset asserted at scan cycle 8000 -> all outputs 0 immediately, res_rd=0. A subsequent start gives correct full results.
